// File: rtl/pkt_gen_burst.sv
// pkt_gen_burst: burst packet source for a switch input port.
// Each packet is a header beat then `length` payload beats, with wr_rdy backpressure.
// Ports: start/dest/prio/length/burst/gap/mode/pattern configure a burst (sampled in IDLE);
//   busy/done report progress; wr_sop/wr_eop/wr_vld/wr_data with wr_rdy form the beat stream.
// The packet priority port is named prio because `priority` is a reserved word.
// Build option PKT_GEN_CHECKSUM_EN appends an XOR trailer beat to packets with payload.
module pkt_gen_burst #(
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_SEL      = 4,
  parameter int WIDTH_PRIORITY = 3,
  parameter int WIDTH_LENGTH   = 10,
  parameter int WIDTH_BURST    = 8,
  parameter int WIDTH_GAP      = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = 32'h0000_0001,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY = 32'h8020_0003
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH_SEL-1:0]      dest,
  input  logic [WIDTH_PRIORITY-1:0] prio,
  input  logic [WIDTH_LENGTH-1:0]   length,
  input  logic [WIDTH_BURST-1:0]    burst,
  input  logic [WIDTH_GAP-1:0]      gap,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     pattern,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_sop,
  output logic                      wr_eop,
  output logic                      wr_vld,
  input  logic                      wr_rdy,
  output logic [DATA_WIDTH-1:0]     wr_data
);

`ifdef PKT_GEN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [WIDTH_LENGTH-1:0] L_ONE = 1;
  localparam logic [WIDTH_BURST-1:0]  B_ONE = 1;
  localparam logic [WIDTH_GAP-1:0]    G_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_PAY, S_TRL, S_GAP, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [WIDTH_SEL-1:0]      dest_q, dest_d;
  logic [WIDTH_PRIORITY-1:0] prio_q, prio_d;
  logic [WIDTH_LENGTH-1:0]   len_q, len_d;
  logic [WIDTH_LENGTH-1:0]   beat_q, beat_d;
  logic [WIDTH_BURST-1:0]    pkt_q, pkt_d;
  logic [WIDTH_GAP-1:0]      gap_q, gap_d;
  logic [WIDTH_GAP-1:0]      gcnt_q, gcnt_d;
  logic [1:0]                mode_q, mode_d;
  logic [DATA_WIDTH-1:0]     pat_q, pat_d;
  logic [DATA_WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]     csum_q, csum_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic busy_q, busy_d, done_q, done_d;
  logic vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic xfer, end_pkt, load_head;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(
    input logic [DATA_WIDTH-1:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pay_word(
    input logic [1:0]              m,
    input logic [WIDTH_LENGTH-1:0] k,
    input logic [DATA_WIDTH-1:0]   s,
    input logic [DATA_WIDTH-1:0]   p
  );
    logic [DATA_WIDTH-1:0] w;
    unique case (m)
      2'd1:    w = s;
      2'd2:    w = p;
      default: w = DATA_WIDTH'(k);
    endcase
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    prio_d    = prio_q;
    len_d     = len_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    lfsr_d    = lfsr_q;
    csum_d    = csum_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    vld_d     = vld_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    end_pkt   = 1'b0;
    load_head = 1'b0;
    xfer      = vld_q && wr_rdy;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dest_d    = dest;
          prio_d    = prio;
          len_d     = length;
          pkt_d     = (burst == '0) ? B_ONE : burst;
          gap_d     = gap;
          mode_d    = mode;
          pat_d     = pattern;
          lfsr_d    = LFSR_SEED;
          busy_d    = 1'b1;
          load_head = 1'b1;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          if (len_q != '0) begin
            state_d = S_PAY;
            beat_d  = '0;
            sop_d   = 1'b0;
            eop_d   = !CSUM_EN && (len_q == L_ONE);
            data_d  = pay_word(mode_q, '0, lfsr_q, pat_q);
          end else begin
            end_pkt = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (xfer) begin
          lfsr_d = lfsr_step(lfsr_q);
          csum_d = csum_q ^ data_q;
          if (beat_q == len_q - L_ONE) begin
            if (CSUM_EN) begin
              state_d = S_TRL;
              eop_d   = 1'b1;
              data_d  = csum_q ^ data_q;
            end else begin
              end_pkt = 1'b1;
            end
          end else begin
            beat_d = beat_q + L_ONE;
            eop_d  = !CSUM_EN && (beat_q + L_ONE == len_q - L_ONE);
            data_d = pay_word(mode_q, beat_q + L_ONE, lfsr_d, pat_q);
          end
        end
      end
      S_TRL: begin
        if (xfer) end_pkt = 1'b1;
      end
      S_GAP: begin
        if (gcnt_q == G_ONE) load_head = 1'b1;
        else gcnt_d = gcnt_q - G_ONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_pkt) begin
      vld_d  = 1'b0;
      sop_d  = 1'b0;
      eop_d  = 1'b0;
      data_d = '0;
      if (pkt_q == B_ONE) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        pkt_d = pkt_q - B_ONE;
        if (gap_q != '0) begin
          state_d = S_GAP;
          gcnt_d  = gap_q;
        end else begin
          load_head = 1'b1;
        end
      end
    end

    if (load_head) begin
      state_d = S_HEAD;
      vld_d   = 1'b1;
      sop_d   = 1'b1;
      eop_d   = (len_d == '0);
      data_d  = DATA_WIDTH'({dest_d, prio_d, len_d});
      csum_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      prio_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      csum_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      prio_q  <= prio_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_vld  = vld_q;
  assign wr_sop  = sop_q;
  assign wr_eop  = eop_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_pkt_gen_burst.sv
// tb_pkt_gen_burst: randomized bench for pkt_gen_burst.
// Expected beats come from a packet-list model built from the burst configuration.
module tb_pkt_gen_burst;
  localparam int DW = 32;
  localparam int WS = 4;
  localparam int WP = 3;
  localparam int WL = 10;
  localparam int WB = 8;
  localparam int WG = 4;

`ifdef PKT_GEN_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [WS-1:0] dest;
  logic [WP-1:0] prio;
  logic [WL-1:0] length;
  logic [WB-1:0] burst;
  logic [WG-1:0] gap;
  logic [1:0]    mode;
  logic [DW-1:0] pattern;
  logic          busy, done, wr_sop, wr_eop, wr_vld, wr_rdy;
  logic [DW-1:0] wr_data;

  int n_assert = 0;
  int n_fail   = 0;

  beat_t exp_q[$];
  beat_t got_q[$];

  pkt_gen_burst dut (
    .clk(clk), .rst(rst), .start(start),
    .dest(dest), .prio(prio), .length(length),
    .burst(burst), .gap(gap), .mode(mode),
    .pattern(pattern), .busy(busy), .done(done),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_rdy(wr_rdy), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet list straight from the burst rules.
  task automatic build(input int d, input int p, input int l, input int b,
                       input int m, input logic [DW-1:0] pat);
    logic [DW-1:0] s, w, x;
    int n;
    s = 32'h1;
    n = (b == 0) ? 1 : b;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b1, l == 0, DW'((d << (WP + WL)) | (p << WL) | l)});
      x = '0;
      for (int k = 0; k < l; k++) begin
        if (m == 1)      w = s;
        else if (m == 2) w = pat;
        else             w = DW'(k);
        exp_q.push_back('{1'b0, (k == l - 1) && (CK == 0), w});
        x = x ^ w;
        s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
      end
      if (CK == 1 && l > 0) exp_q.push_back('{1'b0, 1'b1, x});
    end
  endtask

  task automatic run(input int d, input int p, input int l, input int b,
                     input int g, input int m, input logic [DW-1:0] pat,
                     input int rdy_pct);
    int    cyc, idle, dur, n;
    bit    fin, stalled;
    beat_t cur, snap;
    build(d, p, l, b, m, pat);
    got_q.delete();
    n   = (b == 0) ? 1 : b;
    dur = n * (1 + l + ((CK == 1 && l > 0) ? 1 : 0)) + (n - 1) * g;
    dest = WS'(d); prio = WP'(p); length = WL'(l);
    burst = WB'(b); gap = WG'(g); mode = 2'(m); pattern = pat;
    start = 1'b1;
    wr_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("hdr_latency", wr_vld, 1);
    check("busy_on", busy, 1);
    cyc = 0; idle = 0; fin = 0; stalled = 0; snap = '0;
    while (!fin && cyc < 4000) begin
      cur = '{wr_sop, wr_eop, wr_data};
      if (stalled) begin
        check("stall_hold", cur, snap);
        check("stall_vld", wr_vld, 1);
      end
      if (done) begin
        fin = 1;
        check("done_busy", busy, 0);
        if (rdy_pct == 100) check("duration", cyc, dur);
        start = 1'b1;
      end else begin
        check("busy_in_burst", busy, 1);
        if (wr_vld) begin
          if (rdy_pct == 100 && wr_sop && got_q.size() > 0)
            check("gap_len", idle, g);
          idle = 0;
        end else begin
          idle++;
        end
        dest = WS'($urandom); prio = WP'($urandom);
        length = WL'($urandom); burst = WB'($urandom);
        gap = WG'($urandom); mode = 2'($urandom);
        pattern = $urandom;
        start = ($urandom_range(0, 4) == 0);
        wr_rdy = ($urandom_range(1, 100) <= rdy_pct);
        stalled = wr_vld && !wr_rdy;
        snap = cur;
        if (wr_vld && wr_rdy) begin
          got_q.push_back(cur);
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else check("beat", cur, exp_q.pop_front());
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("no_timeout", fin, 1);
    check("done_pulse", done, 0);
    check("start_in_done_drop", wr_vld, 0);
    check("all_beats_sent", exp_q.size(), 0);
  endtask

  initial begin
    int found;
    rst = 1'b1; start = 1'b0; dest = '0; prio = '0; length = '0;
    burst = '0; gap = '0; mode = '0; pattern = '0; wr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, wr_sop, wr_eop, wr_vld}, 0);
    check("reset_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run(3, 2, 4, 1, 0, 0, '0, 100);
    check("basic_count", got_q.size(), 5 + CK);

    run($urandom_range(0, 15), $urandom_range(0, 7), 0, 3, 2,
        $urandom_range(0, 3), $urandom, 100);
    check("zero_len_count", got_q.size(), 3);

    run(9, 5, 3, 3, 1, 1, '0, 50);

    run(1, 1, 2, 0, 3, 2, $urandom, 70);
    check("burst0_count", got_q.size(), 3 + CK);

    for (int i = 0; i < 5; i++)
      run($urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 6), $urandom_range(0, 4),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
          (i == 0) ? 100 : $urandom_range(40, 100));

    run(2, 4, 3, 2, 0, 1, '0, 100);
    check("lfsr_w0", got_q[1].data, 32'h0000_0001);
    check("lfsr_w1", got_q[2].data, 32'h8020_0003);
    check("lfsr_w2", got_q[3].data, 32'hC030_0002);

    dest = 4'd6; prio = 3'd1; length = 10'd8; burst = 8'd1;
    gap = '0; mode = 2'd0; wr_rdy = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (wr_vld && !wr_sop && wr_data == 32'd2) found = 1;
      else @(negedge clk);
    end
    check("rst_reach_beat2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", {busy, done, wr_sop, wr_eop, wr_vld}, 0);
    check("rst_mid_data", wr_data, 0);
    rst = 1'b0;
    found = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || wr_vld) found = 1;
    end
    check("rst_no_done", found, 0);
    run(6, 1, 8, 1, 0, 0, '0, 100);
    check("post_rst_count", got_q.size(), 9 + CK);

`ifdef PKT_GEN_CHECKSUM_EN
    run(0, 0, 3, 1, 0, 2, 32'hA5A5_A5A5, 100);
    check("csum_odd", got_q[got_q.size()-1], {1'b0, 1'b1, 32'hA5A5_A5A5});
    run(0, 0, 2, 1, 0, 2, 32'hA5A5_A5A5, 100);
    check("csum_even", got_q[got_q.size()-1], {1'b0, 1'b1, 32'h0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_gen_burst.md
Name: pkt_gen_burst

Overview:
Parametrised next-generation packet source for switch input ports. On `start` it emits a burst of 1..N packets on the wr_* write interface, honouring `wr_rdy` backpressure. Each packet is one header beat followed by `length` payload beats. It adds a selectable payload pattern and a programmable inter-packet gap. It drives an input port of the shared-cache switch in benches and self-test.

Parameters:
DATA_WIDTH, 32, width of wr_data.
WIDTH_SEL, 4, destination port field width.
WIDTH_PRIORITY, 3, priority field width.
WIDTH_LENGTH, 10, payload-length field width (max 2^WIDTH_LENGTH-1 beats).
WIDTH_BURST, 8, packets-per-burst field width.
WIDTH_GAP, 4, inter-packet idle-cycle field width.
LFSR_SEED, 32'h0000_0001, LFSR start value (must be nonzero).
LFSR_POLY, 32'h8020_0003, Galois LFSR tap mask.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
dest  in  WIDTH_SEL  destination port.
priority  in  WIDTH_PRIORITY  packet priority.
length  in  WIDTH_LENGTH  payload beats per packet.
burst  in  WIDTH_BURST  packets in burst; 0 treated as 1.
gap  in  WIDTH_GAP  idle cycles between packets.
mode  in  2  payload pattern: 0 = incrementing, 1 = LFSR, 2 = fixed pattern, 3 = same as 0.
pattern  in  DATA_WIDTH  fixed payload word for mode 2.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last beat of the burst is accepted.
wr_sop  out  1  first beat of packet.
wr_eop  out  1  last beat of packet.
wr_vld  out  1  beat valid.
wr_rdy  in  1  sink ready; a beat transfers when wr_vld && wr_rdy.
wr_data  out  DATA_WIDTH  beat data.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: every output 0; state IDLE; internal counters 0; LFSR = LFSR_SEED. Reset mid-packet aborts immediately with no eop and no done.
- Width rule: WIDTH_SEL+WIDTH_PRIORITY+WIDTH_LENGTH <= DATA_WIDTH. Header = {zero pad, dest, priority, length}, with length in the LSBs.
- State machine: IDLE -> HEAD -> PAY -> GAP/HEAD/DONE -> IDLE.
- IDLE: on start, latch dest, priority, length, burst (0->1), gap, mode and pattern; load the LFSR with the seed; go to HEAD. Inputs are ignored while busy, and a start outside IDLE is dropped.
- HEAD: wr_vld=1, wr_sop=1, wr_data=header. wr_eop=1 only if length==0.
  - On transfer: if length>0 go to PAY.
  - Otherwise end the packet (see end-of-packet rule).
- PAY: wr_vld=1, wr_data by mode.
  - Mode 0: beat index k (0..length-1), zero-extended; restarts at 0 every packet.
  - Mode 1: current LFSR value. On each accepted payload beat the LFSR advances: next = (s>>1) ^ (s[0] ? LFSR_POLY : 0). The sequence continues across packets in a burst.
  - Mode 2: the latched pattern word.
  - wr_eop=1 on beat k==length-1; the packet ends on its transfer.
- Outputs are stable while wr_vld && !wr_rdy: data, sop, eop and the LFSR all hold.
- End of packet:
  - If packets remain and gap>0, go to GAP for exactly `gap` cycles with wr_vld=0.
  - If packets remain and gap==0, go to HEAD; the next header is presented the cycle after eop is accepted.
  - If this was the last packet, go to DONE.
- DONE: one cycle, done=1, busy=0 (busy drops in the same cycle), then IDLE. A start is accepted on the cycle after DONE at the earliest.
- Latency: first header valid 1 cycle after start. Zero-backpressure burst duration = burst*(1+length) + (burst-1)*gap beats/cycles.

Optional Feature:
PKT_GEN_CHECKSUM_EN:
- Defined: each packet with length>0 gets one trailer beat after the last payload beat. Trailer = XOR of all payload words of that packet. wr_eop moves from the last payload beat to the trailer.
- length==0 packets get no trailer.
- Undefined: no trailer; eop is on the last payload beat.

Test Plan:
- Basic packet: start, dest=3, priority=2, length=4, burst=1, gap=0, mode=0, wr_rdy=1 -> header then 0,1,2,3. sop on header, eop on beat 3, done one cycle after eop, 5 valid beats.
- Zero length: length=0, burst=3, gap=2 -> three header-only beats, each with sop=eop=1, separated by exactly 2 idle cycles; one done.
- Backpressure: length=3, wr_rdy toggling 1,0,0,1,... -> no beat lost or duplicated. wr_data, sop and eop stay stable while stalled. Mode 1 sequence matches the LFSR reference from seed 1.
- Ignored start: start asserted mid-burst, and burst=0 -> the mid-burst start is ignored; burst=0 sends exactly one packet.
- Reset mid-packet: rst asserted during payload beat 2 of length=8 -> next cycle all outputs 0, no done. A fresh start then produces a correct full packet.
- Checksum (PKT_GEN_CHECKSUM_EN defined): mode 2 with pattern=32'hA5A5_A5A5 and length=3 -> trailer 32'hA5A5_A5A5 with eop on the trailer. Repeat with length=2 -> trailer 0.
